// File: rtl/paq_2b_a_8b_pkg.sv
// Shared widths, FSM state codes and slot-merge helper for the 2-bit to 8-bit packer.
package paq_2b_a_8b_pkg;

  localparam int unsigned PAQ_IN_W  = 2;
  localparam int unsigned PAQ_WORDS = 4;
  localparam int unsigned PAQ_OUT_W = PAQ_IN_W * PAQ_WORDS;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned SH_W      = PAQ_OUT_W - PAQ_IN_W;

  typedef enum logic {
    ST_LLENANDO = 1'b0,
    ST_LLENO    = 1'b1
  } state_e;

  // Write one input word into its slot of the partial-word register.
  function automatic logic [SH_W-1:0] put_slot(input logic [SH_W-1:0] sh,
                                               input logic [CNT_W-1:0] slot,
                                               input logic [PAQ_IN_W-1:0] d);
    logic [SH_W-1:0] r;
    r = sh;
    for (int unsigned i = 0; i < PAQ_WORDS - 1; i++) begin
      if (slot == CNT_W'(i)) r[i*PAQ_IN_W +: PAQ_IN_W] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/paq_2b_a_8b_if.sv
// Valid/ready bus between mux_2b, the packer and the 8-bit consumer.
// parity_out exists only when PAQ_PARITY_EN is defined.
interface paq_2b_a_8b_if;
  import paq_2b_a_8b_pkg::*;

  logic                 valid_in;
  logic [PAQ_IN_W-1:0]  data_in;
  logic                 ready_out;
  logic                 valid_out;
  logic [PAQ_OUT_W-1:0] data_out;
  logic                 ready_in;
`ifdef PAQ_PARITY_EN
  logic                 parity_out;

  modport master (output valid_in, data_in, ready_in,
                  input  ready_out, valid_out, data_out, parity_out);
  modport slave  (input  valid_in, data_in, ready_in,
                  output ready_out, valid_out, data_out, parity_out);
`else
  modport master (output valid_in, data_in, ready_in,
                  input  ready_out, valid_out, data_out);
  modport slave  (input  valid_in, data_in, ready_in,
                  output ready_out, valid_out, data_out);
`endif

endinterface

// File: rtl/paq_2b_a_8b_contador_2b.sv
// Slot counter: sync reset, enable, wraps after the last slot.
module contador_2b
  import paq_2b_a_8b_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last_c
);

  logic [CNT_W-1:0] count_q;

  assign count  = count_q;
  assign last_c = (count_q == CNT_W'(PAQ_WORDS - 1));

  always_ff @(posedge clk) begin
    if (reset)   count_q <= '0;
    else if (en) count_q <= last_c ? '0 : count_q + CNT_W'(1);
  end

endmodule

// File: rtl/paq_2b_a_8b.sv
// Packs four 2-bit words into one 8-bit word with valid/ready on both sides.
// Optional even parity output enabled by defining PAQ_PARITY_EN.
module paq_2b_a_8b
  import paq_2b_a_8b_pkg::*;
(
  input logic          clk,
  input logic          reset,
  paq_2b_a_8b_if.slave bus
);

  state_e               state_q, state_d;
  logic [SH_W-1:0]      sh_q, sh_d;
  logic [PAQ_OUT_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ready_c, accept_c, last_c;
  logic [CNT_W-1:0]     count;

  // In LLENO an input is only taken when the held word leaves on the same edge.
  assign ready_c  = (state_q == ST_LLENANDO) || bus.ready_in;
  assign accept_c = bus.valid_in && ready_c;

  contador_2b u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (accept_c),
    .count (count),
    .last_c(last_c)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_LLENANDO: begin
        if (accept_c) begin
          if (last_c) begin
            data_d  = {bus.data_in, sh_q};
            valid_d = 1'b1;
            state_d = ST_LLENO;
          end else begin
            sh_d = put_slot(sh_q, count, bus.data_in);
          end
        end
      end
      ST_LLENO: begin
        if (bus.ready_in) begin
          valid_d = 1'b0;
          state_d = ST_LLENANDO;
          if (bus.valid_in) sh_d = put_slot(sh_q, count, bus.data_in);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LLENANDO;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_out = ready_c;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

`ifdef PAQ_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ^data_d;
  end

  assign bus.parity_out = parity_q;
`endif

endmodule
